metrics_snapshot: RTL and testbench

Readout stage downstream of the accelerator's `metrics_counter` instances. It atomically captures all counter values into a shadow register bank on request, optionally clears the counters in the same cycle, and streams the captured values out one word per transfer over a valid/ready interface. This lets the debug/host path read a coherent set of performance metrics without halting the datapath.

---
 rtl/metrics_snapshot.sv | 98 +++++++++
 tb/tb_metrics_snapshot.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/metrics_snapshot.sv
// Snapshot/readout stage for the metrics counters: captures every counter on an accepted
// request and streams the frozen copies out one word per valid/ready transfer.
module metrics_snapshot #(
   parameter int NUM_COUNTERS  = 4,
   parameter int COUNTER_WIDTH = 32,
   localparam int IDX_WIDTH    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] cnt_in,
   input  logic                                  snap_req,
   input  logic                                  clear_on_snap,
   output logic                                  cnt_clear,
   output logic                                  busy,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [COUNTER_WIDTH-1:0]              out_data,
   output logic [IDX_WIDTH-1:0]                  out_idx,
   output logic                                  out_last,
   output logic [7:0]                            drop_cnt
);

   localparam logic [0:0]           S_IDLE   = 1'b0;
   localparam logic [0:0]           S_STREAM = 1'b1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTERS - 1);

   logic [0:0]               r_state;
   logic [IDX_WIDTH-1:0]     r_idx;
   logic [COUNTER_WIDTH-1:0] r_shadow [NUM_COUNTERS];
   logic [7:0]               r_drop;

   logic                     w_busy;
   logic                     w_accept;
   logic                     w_reject;
   logic                     w_xfer;
   logic                     w_last;
   logic [COUNTER_WIDTH-1:0] w_word;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_busy   = (r_state == S_STREAM);
   assign w_accept = snap_req & ~w_busy;
   assign w_reject = snap_req & w_busy;
   assign w_xfer   = w_busy & out_ready;
   assign w_last   = w_busy & (r_idx == LAST_IDX);

   // Gated by rst so a request coinciding with reset never wipes the live counters.
   assign cnt_clear = w_accept & clear_on_snap & ~rst;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (w_busy && (r_idx == IDX_WIDTH'(i))) begin
            w_word = r_shadow[i];
         end
      end
   end

   assign out_valid = w_busy;
   assign busy      = w_busy;
   assign out_data  = w_word;
   assign out_idx   = w_busy ? r_idx : '0;
   assign out_last  = w_last;
   assign drop_cnt  = r_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_drop  <= 8'd0;
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
               r_shadow[i] <= cnt_in[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
            r_idx   <= '0;
            r_state <= S_STREAM;
         end else if (w_xfer) begin
            // Return idx to 0 on the last word so non-power-of-two counts never leave it out of range.
            if (w_last) begin
               r_idx   <= '0;
               r_state <= S_IDLE;
            end else begin
               r_idx <= r_idx + IDX_WIDTH'(1);
            end
         end
         if (w_reject) begin
            r_drop <= sat_inc8(r_drop);
         end
      end
   end

endmodule

// File: tb/tb_metrics_snapshot.sv
// Randomized bench for metrics_snapshot: a queue-based reference model predicts the stream,
// clear strobe and drop counter; a behavioural counter exercises clear-on-snapshot.
module tb_metrics_snapshot;

   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, snap_req, clear_on_snap, out_ready;
   logic           ctr_en, use_ctr;
   logic [N*W-1:0] cnt_drv;
   logic [W-1:0]   ctr;
   logic [N*W-1:0] cnt_in;
   logic           cnt_clear, busy, out_valid, out_last;
   logic [W-1:0]   out_data;
   logic [1:0]     out_idx;
   logic [7:0]     drop_cnt;

   logic           snap1, clr_on1, ready1;
   logic [W-1:0]   cnt1;
   logic           clr1, busy1, valid1, last1;
   logic [W-1:0]   data1;
   logic [0:0]     idx1;
   logic [7:0]     drop1;

   assign cnt_in = use_ctr ? {cnt_drv[N*W-1:W], ctr} : cnt_drv;

   metrics_snapshot #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .snap_req(snap_req),
      .clear_on_snap(clear_on_snap), .cnt_clear(cnt_clear), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .drop_cnt(drop_cnt));

   metrics_snapshot #(.NUM_COUNTERS(1), .COUNTER_WIDTH(W)) dut1 (
      .clk(clk), .rst(rst), .cnt_in(cnt1), .snap_req(snap1),
      .clear_on_snap(clr_on1), .cnt_clear(clr1), .busy(busy1),
      .out_valid(valid1), .out_ready(ready1), .out_data(data1),
      .out_idx(idx1), .out_last(last1), .drop_cnt(drop1));

   // Stand-in for a metrics_counter: clear has priority over increment.
   always @(posedge clk) begin
      if (rst)            ctr <= '0;
      else if (cnt_clear) ctr <= '0;
      else if (ctr_en)    ctr <= ctr + 32'd1;
   end

   int           n_chk  = 0;
   int           n_pass = 0;
   logic [W-1:0] mq[$];
   int           m_drop = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic rand_cnt();
      for (int i = 0; i < N; i++) cnt_drv[i*W +: W] = $urandom;
   endtask

   // Checks the current cycle against the model, advances the model, moves to the next negedge.
   task automatic cycle();
      bit m_busy;
      #1;
      m_busy = (mq.size() != 0);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("cnt_clear", 64'(cnt_clear), 64'(snap_req & clear_on_snap & ~m_busy & ~rst));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_busy) begin
         chk("out_data", 64'(out_data), 64'(mq[0]));
         chk("out_idx", 64'(out_idx), 64'(N - mq.size()));
         chk("out_last", 64'(out_last), 64'(mq.size() == 1));
      end
      if (rst) begin
         mq.delete();
         m_drop = 0;
      end else begin
         if (m_busy && out_ready) void'(mq.pop_front());
         if (snap_req) begin
            if (!m_busy) for (int i = 0; i < N; i++) mq.push_back(cnt_in[i*W +: W]);
            else if (m_drop < 255) m_drop++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; snap_req = 1'b0; clear_on_snap = 1'b0; out_ready = 1'b0;
      ctr_en = 1'b0; use_ctr = 1'b0; cnt_drv = '0;
      snap1 = 1'b0; clr_on1 = 1'b0; ready1 = 1'b0; cnt1 = '0;
      repeat (2) @(negedge clk);

      // reset state, with a request colliding with reset
      snap_req = 1'b1; clear_on_snap = 1'b1; cnt_drv = {4{32'h5A5A5A5A}};
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_clear", 64'(cnt_clear), 64'd0);
      chk("rst_valid1", 64'(valid1), 64'd0);
      cycle();
      rst = 1'b0; snap_req = 1'b0; clear_on_snap = 1'b0;
      cycle();

      // basic capture and stream
      cnt_drv = {32'd40, 32'd30, 32'd20, 32'd10};
      snap_req = 1'b1;
      cycle();
      snap_req = 1'b0; out_ready = 1'b1;
      repeat (5) cycle();

      // rejected requests, including one in the final-transfer cycle
      rand_cnt();
      snap_req = 1'b1;
      cycle();
      for (int k = 0; k < 4; k++) begin
         snap_req = (k != 1); clear_on_snap = 1'b1;
         rand_cnt();
         cycle();
      end
      snap_req = 1'b0; clear_on_snap = 1'b0;
      cycle();
      chk("drop_three", 64'(drop_cnt), 64'd3);

      // clear on snapshot against a free-running counter
      use_ctr = 1'b1; ctr_en = 1'b1;
      for (int b = 0; b < 1000 && ctr != 32'd100; b++) cycle();
      snap_req = 1'b1; clear_on_snap = 1'b1;
      cycle();
      snap_req = 1'b0; clear_on_snap = 1'b0;
      chk("ctr_cleared", 64'(ctr), 64'd0);
      chk("clr_word", 64'(out_data), 64'd100);
      repeat (5) cycle();
      use_ctr = 1'b0; ctr_en = 1'b0;

      // backpressure
      rand_cnt();
      snap_req = 1'b1;
      cycle();
      snap_req = 1'b0; out_ready = 1'b0;
      repeat (5) cycle();
      for (int k = 0; k < 12; k++) begin
         out_ready = ((k % 2) == 0);
         cycle();
      end

      // random traffic
      for (int k = 0; k < 400; k++) begin
         snap_req      = ($urandom_range(0, 7) == 0);
         clear_on_snap = 1'($urandom_range(0, 1));
         out_ready     = ($urandom_range(0, 3) != 0);
         rand_cnt();
         cycle();
      end
      snap_req = 1'b0; clear_on_snap = 1'b0; out_ready = 1'b1;
      repeat (6) cycle();

      // 300 rejected requests saturate the drop counter
      rand_cnt();
      snap_req = 1'b1; out_ready = 1'b0;
      repeat (301) cycle();
      snap_req = 1'b0;
      chk("drop_sat", 64'(drop_cnt), 64'd255);
      out_ready = 1'b1;
      repeat (5) cycle();

      // reset mid-stream after idx 1 transfers
      rand_cnt();
      snap_req = 1'b1;
      cycle();
      snap_req = 1'b0; out_ready = 1'b1;
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      rand_cnt();
      snap_req = 1'b1;
      cycle();
      snap_req = 1'b0;
      chk("restart_idx", 64'(out_idx), 64'd0);
      repeat (5) cycle();

      // single-counter instance
      cnt1 = 32'hFFFF_FFFF; snap1 = 1'b1;
      @(negedge clk);
      snap1 = 1'b0; ready1 = 1'b1; cnt1 = 32'h1234_5678;
      #1;
      chk("n1_valid", 64'(valid1), 64'd1);
      chk("n1_data", 64'(data1), 64'hFFFF_FFFF);
      chk("n1_last", 64'(last1), 64'd1);
      chk("n1_idx", 64'(idx1), 64'd0);
      chk("n1_busy", 64'(busy1), 64'd1);
      @(negedge clk);
      #1;
      chk("n1_fall", 64'(valid1), 64'd0);
      snap1 = 1'b1;
      @(negedge clk);
      snap1 = 1'b0;
      #1;
      chk("n1_reaccept", 64'(valid1), 64'd1);
      chk("n1_new_data", 64'(data1), 64'h1234_5678);
      chk("n1_drop", 64'(drop1), 64'd0);
      @(negedge clk);
      #1;
      chk("n1_done", 64'(valid1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
